// File: rtl/clint_pkg.sv
// Shared definitions for the core-local interruptor.
// Register offsets, response codes, decode and strobe helpers.
package clint_pkg;

  localparam logic [15:0] MSIP_OFF     = 16'h0000;
  localparam logic [15:0] MTIMECMP_OFF = 16'h4000;
  localparam logic [15:0] MTIME_OFF    = 16'hBFF8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_RESP = 1'b1
  } rd_state_e;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_MSIP,
    SEL_CMP,
    SEL_MTIME
  } sel_e;

  typedef struct packed {
    sel_e       sel;
    logic [2:0] hart;
    logic       hi;
  } dec_t;

  // Map a base-relative offset to a register; word-aligned only.
  function automatic dec_t decode(
    input logic [31:0] off,
    input logic [3:0]  nh
  );
    dec_t d;
    d.sel  = SEL_NONE;
    d.hart = 3'd0;
    d.hi   = 1'b0;
    if (off[31:16] == 16'h0 && off[1:0] == 2'b00) begin
      if (off[15:5] == MSIP_OFF[15:5]) begin
        if ({1'b0, off[4:2]} < nh) begin
          d.sel  = SEL_MSIP;
          d.hart = off[4:2];
        end
      end else if (off[15:6] == MTIMECMP_OFF[15:6]) begin
        if ({1'b0, off[5:3]} < nh) begin
          d.sel  = SEL_CMP;
          d.hart = off[5:3];
          d.hi   = off[2];
        end
      end else if (off[15:3] == MTIME_OFF[15:3]) begin
        d.sel = SEL_MTIME;
        d.hi  = off[2];
      end
    end
    return d;
  endfunction

  // Byte-lane merge of write data into an existing word.
  function automatic logic [31:0] merge_strb(
    input logic [31:0] old,
    input logic [31:0] data,
    input logic [3:0]  strb
  );
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) r[8*b +: 8] = data[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/clint_tick_gen.sv
// Prescaler for mtime: pulses tick once every TICK_DIV cycles.
// A clear restarts the count so a fresh mtime gets a full period.
module clint_tick_gen #(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CW =
    (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick = (cnt_q == LAST);

  // Next count: wrap on tick, restart on clear.
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (tick || clr) cnt_d = '0;
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/clint_timer.sv
// Core-local interruptor: mtime, per-hart mtimecmp and msip
// behind an AXI4-Lite slave, driving mtip/msip irq lines.
import clint_pkg::*;

module clint_timer #(
  parameter int unsigned NUM_HARTS = 1,
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
  parameter int unsigned TICK_DIV  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [31:0]          awaddr,
  input  logic                 awvalid,
  output logic                 awready,
  input  logic [31:0]          wdata,
  input  logic [3:0]           wstrb,
  input  logic                 wvalid,
  output logic                 wready,
  output logic [1:0]           bresp,
  output logic                 bvalid,
  input  logic                 bready,
  input  logic [31:0]          araddr,
  input  logic                 arvalid,
  output logic                 arready,
  output logic [31:0]          rdata,
  output logic [1:0]           rresp,
  output logic                 rvalid,
  input  logic                 rready,
  output logic [NUM_HARTS-1:0] mtip,
  output logic [NUM_HARTS-1:0] msip
);

  localparam logic [3:0] NH = 4'(NUM_HARTS);

  logic tick;
  logic tick_clr;

  logic [63:0]                mtime_q, mtime_d, mtime_inc;
  logic [NUM_HARTS-1:0][63:0] cmp_q, cmp_d;
  logic [NUM_HARTS-1:0]       msip_q, msip_d;
  logic [NUM_HARTS-1:0]       mtip_q, mtip_d;

  logic        awready_q, awready_d;
  logic        wready_q, wready_d;
  logic        aw_got_q, aw_got_d;
  logic        w_got_q, w_got_d;
  logic        bvalid_q, bvalid_d;
  logic [1:0]  bresp_q, bresp_d;
  logic [31:0] awaddr_q, awaddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        do_wr;

  rd_state_e   rstate_q;
  logic        arready_q, rvalid_q;
  logic [31:0] rdata_q;
  logic [1:0]  rresp_q;
  logic [31:0] rd_data;
  logic        rd_err;

  dec_t wdec;
  dec_t rdec;

  assign wdec = decode(awaddr_q - BASE_ADDR, NH);
  assign rdec = decode(araddr - BASE_ADDR, NH);

  clint_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (tick_clr),
    .tick (tick)
  );

  // Write channels: capture AW and W independently, then commit once.
  always_comb begin
    awready_d = awready_q;
    wready_d  = wready_q;
    aw_got_d  = aw_got_q;
    w_got_d   = w_got_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    do_wr     = aw_got_q && w_got_q;
    if (awvalid && awready_q) begin
      awready_d = 1'b0;
      aw_got_d  = 1'b1;
      awaddr_d  = awaddr;
    end
    if (wvalid && wready_q) begin
      wready_d = 1'b0;
      w_got_d  = 1'b1;
      wdata_d  = wdata;
      wstrb_d  = wstrb;
    end
    if (do_wr) begin
      aw_got_d = 1'b0;
      w_got_d  = 1'b0;
      bvalid_d = 1'b1;
      bresp_d  = (wdec.sel == SEL_NONE) ? RESP_SLVERR : RESP_OKAY;
    end
    if (bvalid_q && bready) begin
      bvalid_d  = 1'b0;
      awready_d = 1'b1;
      wready_d  = 1'b1;
    end
  end

  // Write-channel registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      awready_q <= 1'b1;
      wready_q  <= 1'b1;
      aw_got_q  <= 1'b0;
      w_got_q   <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else begin
      awready_q <= awready_d;
      wready_q  <= wready_d;
      aw_got_q  <= aw_got_d;
      w_got_q   <= w_got_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
    end
  end

  // Register file next state: free-running mtime plus committed writes.
  always_comb begin
    mtime_inc = mtime_q + 64'(tick);
    mtime_d   = mtime_inc;
    cmp_d     = cmp_q;
    msip_d    = msip_q;
    tick_clr  = 1'b0;
    if (do_wr) begin
      case (wdec.sel)
        SEL_MSIP: begin
          for (int h = 0; h < int'(NUM_HARTS); h++) begin
            if (wdec.hart == 3'(h) && wstrb_q[0]) msip_d[h] = wdata_q[0];
          end
        end
        SEL_CMP: begin
          for (int h = 0; h < int'(NUM_HARTS); h++) begin
            if (wdec.hart == 3'(h)) begin
              if (wdec.hi)
                cmp_d[h][63:32] = merge_strb(cmp_q[h][63:32], wdata_q, wstrb_q);
              else
                cmp_d[h][31:0] = merge_strb(cmp_q[h][31:0], wdata_q, wstrb_q);
            end
          end
        end
        SEL_MTIME: begin
          tick_clr = 1'b1;
          if (wdec.hi)
            mtime_d[63:32] = merge_strb(mtime_inc[63:32], wdata_q, wstrb_q);
          else
            mtime_d[31:0] = merge_strb(mtime_inc[31:0], wdata_q, wstrb_q);
        end
        default: ;
      endcase
    end
    for (int h = 0; h < int'(NUM_HARTS); h++) begin
      mtip_d[h] = (mtime_q >= cmp_q[h]);
    end
  end

  // Register file state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mtime_q <= '0;
      cmp_q   <= '1;
      msip_q  <= '0;
      mtip_q  <= '0;
    end else begin
      mtime_q <= mtime_d;
      cmp_q   <= cmp_d;
      msip_q  <= msip_d;
      mtip_q  <= mtip_d;
    end
  end

  // Read mux from current register state.
  always_comb begin
    rd_data = '0;
    rd_err  = 1'b0;
    case (rdec.sel)
      SEL_MSIP: begin
        for (int h = 0; h < int'(NUM_HARTS); h++) begin
          if (rdec.hart == 3'(h)) rd_data = {31'd0, msip_q[h]};
        end
      end
      SEL_CMP: begin
        for (int h = 0; h < int'(NUM_HARTS); h++) begin
          if (rdec.hart == 3'(h))
            rd_data = rdec.hi ? cmp_q[h][63:32] : cmp_q[h][31:0];
        end
      end
      SEL_MTIME: rd_data = rdec.hi ? mtime_q[63:32] : mtime_q[31:0];
      default:   rd_err  = 1'b1;
    endcase
  end

  // Read FSM: accept AR, hold R until the master takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rstate_q  <= R_IDLE;
      arready_q <= 1'b1;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      case (rstate_q)
        R_IDLE: begin
          if (arvalid && arready_q) begin
            rstate_q  <= R_RESP;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b1;
            rdata_q   <= rd_data;
            rresp_q   <= rd_err ? RESP_SLVERR : RESP_OKAY;
          end
        end
        R_RESP: begin
          if (rready) begin
            rstate_q  <= R_IDLE;
            rvalid_q  <= 1'b0;
            arready_q <= 1'b1;
          end
        end
        default: rstate_q <= R_IDLE;
      endcase
    end
  end

  assign awready = awready_q;
  assign wready  = wready_q;
  assign bvalid  = bvalid_q;
  assign bresp   = bresp_q;
  assign arready = arready_q;
  assign rvalid  = rvalid_q;
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;
  assign mtip    = mtip_q;
  assign msip    = msip_q;

endmodule

// File: tb/tb_clint_timer.sv
// Scoreboard bench for clint_timer (2 harts, prescale 4).
// Stimulus queues expected R/B beats; a monitor pops and compares.
module tb_clint_timer;

  localparam logic [31:0] BASE = 32'h0200_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic        awvalid, awready, wvalid, wready;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        bvalid, bready, arvalid, arready, rvalid, rready;
  logic [1:0]  mtip, msip;

  typedef struct {
    string       name;
    logic [31:0] lo;
    logic [31:0] hi;
    logic [1:0]  resp;
  } exp_t;

  exp_t rq[$];
  exp_t bq[$];
  int   n_pass = 0;
  int   n_total = 0;
  int   r_seen = 0;
  int   b_seen = 0;

  clint_timer #(
    .NUM_HARTS(2),
    .BASE_ADDR(BASE),
    .TICK_DIV (4)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .awaddr (awaddr),
    .awvalid(awvalid),
    .awready(awready),
    .wdata  (wdata),
    .wstrb  (wstrb),
    .wvalid (wvalid),
    .wready (wready),
    .bresp  (bresp),
    .bvalid (bvalid),
    .bready (bready),
    .araddr (araddr),
    .arvalid(arvalid),
    .arready(arready),
    .rdata  (rdata),
    .rresp  (rresp),
    .rvalid (rvalid),
    .rready (rready),
    .mtip   (mtip),
    .msip   (msip)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: sim time %0t exceeded", $time);
    $fatal(1, "watchdog");
  end

  // Monitor: pop and compare whenever a response beat completes.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && rvalid && rready) begin
      r_seen++;
      n_total++;
      if (rq.size() == 0) begin
        $display("FAIL unexpected_r: rdata %h rresp %b", rdata, rresp);
      end else begin
        e = rq.pop_front();
        if (rresp === e.resp && rdata >= e.lo && rdata <= e.hi)
          n_pass++;
        else
          $display("FAIL %s: rdata %h rresp %b, want %h..%h resp %b",
                   e.name, rdata, rresp, e.lo, e.hi, e.resp);
      end
    end
    if (rst_n && bvalid && bready) begin
      b_seen++;
      n_total++;
      if (bq.size() == 0) begin
        $display("FAIL unexpected_b: bresp %b", bresp);
      end else begin
        e = bq.pop_front();
        if (bresp === e.resp)
          n_pass++;
        else
          $display("FAIL %s: bresp %b, want %b", e.name, bresp, e.resp);
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", name, act, exp);
  endtask

  task automatic wait_b(input int start, input string name);
    int k = 0;
    while (b_seen == start && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (b_seen == start) begin
      n_total++;
      $display("FAIL %s_btimeout: got no B, want one", name);
      bq.delete();
    end
  endtask

  task automatic wr(input logic [15:0] off, input logic [31:0] d,
                    input logic [3:0] s, input logic [1:0] resp,
                    input string name);
    int start;
    int k = 0;
    bq.push_back('{name, 32'd0, 32'd0, resp});
    start = b_seen;
    @(negedge clk);
    awaddr  = BASE + 32'(off);
    wdata   = d;
    wstrb   = s;
    awvalid = 1'b1;
    wvalid  = 1'b1;
    while (!(awready && wready) && k < 50) begin
      @(negedge clk);
      k++;
    end
    @(posedge clk);
    #1;
    awvalid = 1'b0;
    wvalid  = 1'b0;
    wait_b(start, name);
  endtask

  task automatic rd(input logic [15:0] off, input logic [31:0] lo,
                    input logic [31:0] hi, input logic [1:0] resp,
                    input string name);
    int start;
    int k = 0;
    rq.push_back('{name, lo, hi, resp});
    start = r_seen;
    @(negedge clk);
    araddr  = BASE + 32'(off);
    arvalid = 1'b1;
    while (!arready && k < 50) begin
      @(negedge clk);
      k++;
    end
    @(posedge clk);
    #1;
    arvalid = 1'b0;
    k = 0;
    while (r_seen == start && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (r_seen == start) begin
      n_total++;
      $display("FAIL %s_rtimeout: got no R, want one", name);
      rq.delete();
    end
  endtask

  initial begin
    int k;
    int start;
    rst_n   = 1'b0;
    awaddr  = '0;
    wdata   = '0;
    wstrb   = '0;
    araddr  = '0;
    awvalid = 1'b0;
    wvalid  = 1'b0;
    arvalid = 1'b0;
    bready  = 1'b1;
    rready  = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_awready", awready, 1);
    check("rst_wready", wready, 1);
    check("rst_arready", arready, 1);
    check("rst_valids", {rvalid, bvalid}, 0);
    check("rst_irqs", {mtip, msip}, 0);
    rst_n = 1'b1;

    // Free-running mtime after reset, reset register values.
    repeat (10) @(negedge clk);
    rd(16'hBFF8, 32'd1, 32'd4, 2'b00, "mtime_lo_boot");
    rd(16'h4000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00, "cmp0_lo_rst");
    rd(16'h4004, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00, "cmp0_hi_rst");
    rd(16'h0000, 32'd0, 32'd0, 2'b00, "msip0_rst");

    // Prescaled count: 40 cycles at divide-by-4 is about 10.
    wr(16'hBFF8, 32'd0, 4'hF, 2'b00, "wr_mtime_lo0");
    repeat (40) @(negedge clk);
    rd(16'hBFF8, 32'd9, 32'd12, 2'b00, "mtime_lo_40");
    rd(16'hBFFC, 32'd0, 32'd0, 2'b00, "mtime_hi_40");

    // Timer compare rise and clear.
    wr(16'hBFF8, 32'd0, 4'hF, 2'b00, "wr_mtime_lo0b");
    wr(16'h4000, 32'h20, 4'hF, 2'b00, "wr_cmp0_lo");
    wr(16'h4004, 32'h0, 4'hF, 2'b00, "wr_cmp0_hi");
    check("mtip_before", mtip, 2'b00);
    k = 0;
    while (!mtip[0] && k < 400) begin
      @(negedge clk);
      k++;
    end
    check("mtip0_rise", mtip, 2'b01);
    rd(16'hBFF8, 32'h20, 32'h22, 2'b00, "mtime_at_mtip");
    wr(16'h4000, 32'hFFFF_FFFF, 4'hF, 2'b00, "wr_cmp0_lo_max");
    @(negedge clk);
    check("mtip0_fall", mtip, 2'b00);

    // Software interrupts with RAZ/WI upper bits and strobes.
    wr(16'h0004, 32'd1, 4'hF, 2'b00, "wr_msip1");
    check("msip_out_10", msip, 2'b10);
    wr(16'h0004, 32'hFFFF_FFFF, 4'hF, 2'b00, "wr_msip1_all");
    rd(16'h0004, 32'd1, 32'd1, 2'b00, "msip1_raz");
    wr(16'h0000, 32'hFFFF_FFFE, 4'hF, 2'b00, "wr_msip0_hi");
    rd(16'h0000, 32'd0, 32'd0, 2'b00, "msip0_bit0");
    wr(16'h0004, 32'd0, 4'b1110, 2'b00, "wr_msip1_nostrb");
    rd(16'h0004, 32'd1, 32'd1, 2'b00, "msip1_strb");
    check("msip_out_still", msip, 2'b10);

    // Carry from lo into hi.
    wr(16'hBFFC, 32'd0, 4'hF, 2'b00, "wr_mtime_hi0");
    wr(16'hBFF8, 32'hFFFF_FFFF, 4'hF, 2'b00, "wr_mtime_lo_max");
    rd(16'hBFF8, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00, "mtime_lo_pre");
    repeat (4) @(negedge clk);
    rd(16'hBFFC, 32'd1, 32'd1, 2'b00, "mtime_hi_carry");
    rd(16'hBFF8, 32'd0, 32'd6, 2'b00, "mtime_lo_carry");

    // Decode errors.
    rd(16'h8000, 32'd0, 32'd0, 2'b10, "rd_bad_off");
    rd(16'h0008, 32'd0, 32'd0, 2'b10, "rd_msip_h2");
    wr(16'h8000, 32'h55, 4'hF, 2'b10, "wr_bad_off");

    // AW then W two cycles later yields a single B.
    bq.push_back('{"split_b", 32'd0, 32'd0, 2'b00});
    start = b_seen;
    @(negedge clk);
    awaddr  = BASE + 32'h4008;
    awvalid = 1'b1;
    k = 0;
    while (!awready && k < 50) begin
      @(negedge clk);
      k++;
    end
    @(posedge clk);
    #1;
    awvalid = 1'b0;
    repeat (2) @(negedge clk);
    check("split_hold", {bvalid, awready, wready}, 3'b001);
    wdata  = 32'h1234;
    wstrb  = 4'hF;
    wvalid = 1'b1;
    k = 0;
    while (!wready && k < 50) begin
      @(negedge clk);
      k++;
    end
    @(posedge clk);
    #1;
    wvalid = 1'b0;
    wait_b(start, "split");
    repeat (4) @(negedge clk);
    check("split_one_b", 64'(b_seen - start), 1);
    rd(16'h4008, 32'h1234, 32'h1234, 2'b00, "cmp1_lo");
    rd(16'h400C, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00, "cmp1_hi");

    // Reset with a half-done write pending.
    @(negedge clk);
    awaddr  = BASE + 32'h4000;
    awvalid = 1'b1;
    @(posedge clk);
    #1;
    awvalid = 1'b0;
    @(negedge clk);
    check("pend_awready", awready, 0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", {awready, wready, arready}, 3'b111);
    check("mid_rst_state", {bvalid, rvalid, mtip, msip}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    rd(16'h4000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00, "cmp0_after_rst");
    rd(16'h0004, 32'd0, 32'd0, 2'b00, "msip1_after_rst");

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
